// File: rtl/keypad_scanner_if.sv
// Pin and key-event bundle for keypad_scanner: matrix row/col lines plus the debounced key bus.
// key_valid / key_release are single-cycle strobes with no back-pressure; key_code is valid whenever either strobes.
interface keypad_scanner_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_release;
    logic       key_held;
    logic [4:0] key_state;
    logic       dbg_pressed;   // stable FSM state, 1 = PRESSED

    modport master (
        input  col,
        output row, key_code, key_valid, key_release, key_held, key_state, dbg_pressed
    );
    modport slave (
        output col,
        input  row, key_code, key_valid, key_release, key_held, key_state, dbg_pressed
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix scanner: row drive, column sync, per-frame debounce and ghost rejection, press/release events.
// Optional auto-repeat of key_valid while a key is held is compiled in with `define KEY_REPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_DELAY    = 250,
    parameter int REPEAT_RATE     = 50
) (
    input  logic             clk_raw,
    input  logic             reset,
    keypad_scanner_if.master kp
);
    localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]        DEB      = 4'(DEBOUNCE_FRAMES);

    if (SCAN_DIV < 3 || DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("keypad_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} frame_cls_t;
    typedef enum logic {IDLE, PRESSED} state_t;

    logic [3:0]       col_s1, col_s2;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic [15:0]      hit;          // active-high key-down bits, bit index = {row, col}
    logic             frame_done;

    // ---------------- scan and capture ----------------
    always_ff @(posedge clk_raw) begin
        if (reset) begin
            col_s1     <= 4'hF;
            col_s2     <= 4'hF;
            div_cnt    <= '0;
            row_idx    <= 2'd0;
            hit        <= '0;
            frame_done <= 1'b0;
        end else begin
            col_s1     <= kp.col;
            col_s2     <= col_s1;
            frame_done <= 1'b0;
            if (frame_done)
                hit <= '0;
            if (div_cnt == DIV_LAST) begin
                div_cnt                   <= '0;
                hit[{row_idx, 2'b00} +: 4] <= ~col_s2;
                row_idx                   <= row_idx + 2'd1;
                frame_done                <= (row_idx == 2'd3);
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // ---------------- frame classification ----------------
    logic [4:0]  hit_cnt;
    logic [3:0]  hit_code;
    frame_cls_t  frame_cls;
    logic [3:0]  frame_code;

    always_comb begin
        hit_cnt  = '0;
        hit_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (hit[i]) begin
                hit_cnt  = hit_cnt + 5'd1;
                hit_code = 4'(i);
            end
        end
        frame_cls  = (hit_cnt == 5'd0) ? CLS_NONE :
                     (hit_cnt == 5'd1) ? CLS_SINGLE : CLS_MULTI;
        frame_code = (frame_cls == CLS_SINGLE) ? hit_code : 4'd0;
    end

    // ---------------- debounce ----------------
    frame_cls_t cand_cls;
    logic [3:0] cand_code;
    logic       cand_valid;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       frame_same;
    logic       accept;

    always_comb begin
        frame_same = cand_valid && (cand_cls == frame_cls) && (cand_code == frame_code);
        cnt_next   = frame_same ? ((cnt == DEB) ? cnt : cnt + 4'd1) : 4'd1;
        accept     = frame_done && (frame_cls != CLS_MULTI) && (cnt_next == DEB);
    end

    always_ff @(posedge clk_raw) begin
        if (reset) begin
            cand_cls   <= CLS_NONE;
            cand_code  <= 4'd0;
            cand_valid <= 1'b0;
            cnt        <= 4'd0;
        end else if (frame_done) begin
            // Ghosted frames restart the debounce without disturbing the stable state.
            if (frame_cls == CLS_MULTI) begin
                cand_valid <= 1'b0;
                cnt        <= 4'd0;
            end else begin
                cand_cls   <= frame_cls;
                cand_code  <= frame_code;
                cand_valid <= 1'b1;
                cnt        <= cnt_next;
            end
        end
    end

    // ---------------- stable FSM ----------------
    state_t     state, state_n;
    logic [3:0] key_code_r, code_n;
    logic       held_r, held_n;
    logic       valid_r, valid_n;
    logic       release_r, release_n;
    logic       rep_fire;

`ifdef KEY_REPEAT_EN
    logic [15:0] rep_cnt;
    logic [15:0] rep_inc;
    logic        rep_first;
    logic        rep_tick;

    always_comb begin
        rep_tick = (state == PRESSED) && frame_done && (frame_cls == CLS_SINGLE) &&
                   (frame_code == key_code_r);
        rep_inc  = rep_cnt + 16'd1;
        rep_fire = rep_tick &&
                   (rep_inc == (rep_first ? 16'(REPEAT_DELAY) : 16'(REPEAT_RATE)));
    end

    always_ff @(posedge clk_raw) begin
        if (reset || state_n != PRESSED || code_n != key_code_r) begin
            rep_cnt   <= 16'd0;
            rep_first <= 1'b1;
        end else if (rep_fire) begin
            rep_cnt   <= 16'd0;
            rep_first <= 1'b0;
        end else if (rep_tick) begin
            rep_cnt <= rep_inc;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        code_n    = key_code_r;
        held_n    = held_r;
        valid_n   = 1'b0;
        release_n = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (frame_cls == CLS_SINGLE) begin
                        code_n  = frame_code;
                        held_n  = 1'b1;
                        valid_n = 1'b1;
                        state_n = PRESSED;
                    end
                end
                PRESSED: begin
                    if (frame_cls == CLS_SINGLE && frame_code != key_code_r) begin
                        code_n  = frame_code;
                        valid_n = 1'b1;
                    end else if (frame_cls == CLS_NONE) begin
                        held_n    = 1'b0;
                        release_n = 1'b1;
                        state_n   = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        if (rep_fire)
            valid_n = 1'b1;
    end

    always_ff @(posedge clk_raw) begin
        if (reset) begin
            state      <= IDLE;
            key_code_r <= 4'd0;
            held_r     <= 1'b0;
            valid_r    <= 1'b0;
            release_r  <= 1'b0;
        end else begin
            state      <= state_n;
            key_code_r <= code_n;
            held_r     <= held_n;
            valid_r    <= valid_n;
            release_r  <= release_n;
        end
    end

    assign kp.row         = ~(4'b0001 << row_idx);
    assign kp.key_code    = key_code_r;
    assign kp.key_valid   = valid_r;
    assign kp.key_release = release_r;
    assign kp.key_held    = held_r;
    assign kp.key_state   = {held_r, key_code_r};
    assign kp.dbg_pressed = (state == PRESSED);
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: key matrix model on row/col, event scoreboard, directed scenarios.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int RDELAY   = 4;
    localparam int RRATE    = 2;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk_raw = 1'b0;
    logic        reset   = 1'b1;
    logic [15:0] key_mask = 16'h0;

    keypad_scanner_if kp ();

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DEB),
        .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
    ) dut (
        .clk_raw(clk_raw),
        .reset  (reset),
        .kp     (kp)
    );

    always #5 clk_raw = ~clk_raw;

    // Key matrix: a held key pulls its column low while its row is driven low.
    always_comb begin
        kp.col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!kp.row[r]) kp.col = kp.col & ~key_mask[r*4 +: 4];
    end

    // Scoreboard entry: {is_press, code}; equals key_state right after the event.
    logic [4:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int valid_seen = 0;
    int release_seen = 0;
    logic       prev_pulse = 1'b0;
    logic       pulse_now;
    logic [4:0] exp_ev;
    logic [4:0] got_ev;

    always @(negedge clk_raw) begin
        pulse_now = kp.key_valid | kp.key_release;
        if (pulse_now) begin
            if (kp.key_valid) valid_seen++;
            if (kp.key_release) release_seen++;
            n_vec++;
            if (kp.key_valid && kp.key_release) begin
                n_err++;
                $display("FAIL event_overlap: valid=%b release=%b, required not both high", kp.key_valid, kp.key_release);
            end
            n_vec++;
            if (prev_pulse) begin
                n_err++;
                $display("FAIL pulse_width: pulse high 2 cycles at %0t, required 1 cycle", $time);
            end
            n_vec++;
            got_ev = {kp.key_valid, kp.key_code};
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: got {valid,code}=%b at %0t, required no event", got_ev, $time);
            end else begin
                exp_ev = exp_q.pop_front();
                if (got_ev !== exp_ev || kp.key_state !== exp_ev) begin
                    n_err++;
                    $display("FAIL event: got {valid,code}=%b key_state=%b, required %b", got_ev, kp.key_state, exp_ev);
                end
            end
        end
        prev_pulse = pulse_now;
    end

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(negedge clk_raw);
    endtask

    // Leaves the bench at the first negedge of a frame (row 0 just driven).
    task automatic align_frame();
        int guard = 0;
        while (kp.row === 4'b1110 && guard < 40) begin
            @(negedge clk_raw);
            guard++;
        end
        while (kp.row !== 4'b1110 && guard < 80) begin
            @(negedge clk_raw);
            guard++;
        end
        if (guard >= 80) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_align: row=%b never returned to 1110", kp.row);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_row;
        reset = 1'b1;
        repeat (2) @(negedge clk_raw);
        n_vec++;
        if ({kp.row, kp.key_state, kp.key_code, kp.key_valid, kp.key_release, kp.key_held} !== {4'b1110, 12'h0}) begin
            n_err++;
            $display("FAIL reset_outputs: row=%b state=%b code=%h v=%b r=%b h=%b, required 1110 and zeros",
                     kp.row, kp.key_state, kp.key_code, kp.key_valid, kp.key_release, kp.key_held);
        end
        reset = 1'b0;
        for (int m = 1; m <= 16; m++) begin
            @(negedge clk_raw);
            exp_row = ~(4'b0001 << ((m / 4) % 4));
            n_vec++;
            if (kp.row !== exp_row) begin
                n_err++;
                $display("FAIL row_scan: cycle %0d row=%b, required %b", m, kp.row, exp_row);
            end
        end
    endtask

    task automatic test_press();
        int start;
        int i;
        align_frame();
        start = valid_seen;
        key_mask = 16'h1 << 5;
        exp_q.push_back({1'b1, 4'd5});
        for (i = 0; i < 4 * FRAME + 3 && valid_seen == start; i++) @(negedge clk_raw);
        n_vec++;
        if (valid_seen != start + 1) begin
            n_err++;
            $display("FAIL press_latency: %0d key_valid pulses after %0d cycles, required 1", valid_seen - start, i);
        end
        align_frame();
        wait_frames(2);
        n_vec++;
        if (kp.key_code !== 4'd5 || kp.key_held !== 1'b1 || kp.key_state !== 5'b10101 || kp.dbg_pressed !== 1'b1) begin
            n_err++;
            $display("FAIL press_state: code=%h held=%b state=%b pressed=%b, required 5 1 10101 1",
                     kp.key_code, kp.key_held, kp.key_state, kp.dbg_pressed);
        end
    endtask

    task automatic test_release();
        int start;
        start = release_seen;
        key_mask = 16'h0;
        exp_q.push_back({1'b0, 4'd5});
        wait_frames(4);
        n_vec++;
        if (release_seen != start + 1 || kp.key_held !== 1'b0 || kp.key_code !== 4'd5 || kp.key_state !== 5'b00101) begin
            n_err++;
            $display("FAIL release: pulses=%0d held=%b code=%h state=%b, required 1 0 5 00101",
                     release_seen - start, kp.key_held, kp.key_code, kp.key_state);
        end
    endtask

    task automatic test_bounce();
        int sv;
        int sr;
        sv = valid_seen;
        sr = release_seen;
        align_frame();
        for (int k = 0; k < 4; k++) begin
            key_mask = 16'h1 << 2;
            wait_frames(1);
            key_mask = 16'h0;
            wait_frames(1);
        end
        wait_frames(4);
        n_vec++;
        if (valid_seen != sv || release_seen != sr || kp.key_held !== 1'b0) begin
            n_err++;
            $display("FAIL bounce: valid=%0d release=%0d held=%b, required 0 0 0",
                     valid_seen - sv, release_seen - sr, kp.key_held);
        end
    endtask

    task automatic test_debounce_boundary();
        int sv;
        sv = valid_seen;
        align_frame();
        key_mask = 16'h1 << 7;
        wait_frames(DEB - 1);
        key_mask = 16'h0;
        wait_frames(4);
        n_vec++;
        if (valid_seen != sv) begin
            n_err++;
            $display("FAIL short_press: %0d key_valid pulses, required 0", valid_seen - sv);
        end
        key_mask = 16'h1 << 7;
        exp_q.push_back({1'b1, 4'd7});
        wait_frames(DEB);
        key_mask = 16'h0;
        exp_q.push_back({1'b0, 4'd7});
        wait_frames(4);
        n_vec++;
        if (valid_seen != sv + 1) begin
            n_err++;
            $display("FAIL exact_press: %0d key_valid pulses, required 1", valid_seen - sv);
        end
    endtask

    task automatic test_ghost_and_reset();
        int sv;
        int sr;
        sv = valid_seen;
        align_frame();
        key_mask = (16'h1 << 0) | (16'h1 << 15);
        wait_frames(5);
        n_vec++;
        if (valid_seen != sv || kp.key_held !== 1'b0) begin
            n_err++;
            $display("FAIL ghost: valid=%0d held=%b, required 0 0", valid_seen - sv, kp.key_held);
        end
        key_mask = 16'h1 << 0;
        exp_q.push_back({1'b1, 4'd0});
        wait_frames(4);
        n_vec++;
        if (kp.key_held !== 1'b1 || kp.key_code !== 4'd0 || valid_seen != sv + 1) begin
            n_err++;
            $display("FAIL ghost_resolve: held=%b code=%h valid=%0d, required 1 0 1",
                     kp.key_held, kp.key_code, valid_seen - sv);
        end
        sr = release_seen;
        reset = 1'b1;
        key_mask = 16'h0;
        @(negedge clk_raw);
        n_vec++;
        if ({kp.row, kp.key_state, kp.key_valid, kp.key_release, kp.key_held, kp.dbg_pressed} !== {4'b1110, 9'h0}) begin
            n_err++;
            $display("FAIL mid_reset: row=%b state=%b v=%b r=%b h=%b pressed=%b, required 1110 and zeros",
                     kp.row, kp.key_state, kp.key_valid, kp.key_release, kp.key_held, kp.dbg_pressed);
        end
        @(negedge clk_raw);
        reset = 1'b0;
        wait_frames(5);
        n_vec++;
        if (release_seen != sr || kp.key_held !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_release: releases=%0d held=%b, required 0 0", release_seen - sr, kp.key_held);
        end
    endtask

    task automatic test_back_to_back();
        int sv;
        sv = valid_seen;
        align_frame();
        key_mask = 16'h1 << 10;
        exp_q.push_back({1'b1, 4'd10});
        wait_frames(3);
        key_mask = 16'h1 << 9;
        exp_q.push_back({1'b1, 4'd9});
`ifdef KEY_REPEAT_EN
        for (int k = 0; k < 3; k++) exp_q.push_back({1'b1, 4'd9});
`endif
        wait_frames(12);
        n_vec++;
        if (kp.key_code !== 4'd9 || kp.key_held !== 1'b1) begin
            n_err++;
            $display("FAIL code_change: code=%h held=%b, required 9 1", kp.key_code, kp.key_held);
        end
        key_mask = 16'h0;
        exp_q.push_back({1'b0, 4'd9});
        wait_frames(4);
        n_vec++;
`ifdef KEY_REPEAT_EN
        if (valid_seen != sv + 5) begin
            n_err++;
            $display("FAIL hold_pulses: %0d key_valid pulses, required 5", valid_seen - sv);
        end
`else
        if (valid_seen != sv + 2) begin
            n_err++;
            $display("FAIL hold_pulses: %0d key_valid pulses, required 2", valid_seen - sv);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_debounce_boundary();
        test_ghost_and_reset();
        test_back_to_back();
        wait_frames(1);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_events: %0d expected events never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream input stage for the music player.
- Drives the active-low row lines of the 4x4 key matrix and samples the active-low column lines.
- Debounces each scan frame and resolves ghosting (multiple keys down).
- Delivers a clean 4-bit key code with press/release pulses to the note-selection logic; code {row_idx, col_idx} matches the keyboard numbering used by the player (row 1101 / col 1101 = key 5).

Parameters:
- SCAN_DIV, 50000, clk_raw cycles each row stays driven (1 ms at 50 MHz); must be >= 3.
- DEBOUNCE_FRAMES, 4, consecutive identical frames required to accept a new stable state; range 1..15.
- REPEAT_DELAY, 250, frames held before the first auto-repeat (KEY_REPEAT_EN only).
- REPEAT_RATE, 50, frames between later auto-repeats (KEY_REPEAT_EN only).

Ports:
- clk_raw  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- col  in  4  matrix columns, active-low, asynchronous; bit0 = col0.
- row  out  4  matrix rows, one-hot-low; bit0 = row0.
- key_code  out  4  last accepted key, {row_idx[1:0], col_idx[1:0]}.
- key_valid  out  1  one-cycle pulse when a key press is accepted.
- key_release  out  1  one-cycle pulse when release is accepted.
- key_held  out  1  high while the accepted state is "key down".
- key_state  out  5  {key_held, key_code}; same format as the player's keyboard bus.

Behaviour:
- Reset values: row=4'b1110; key_code=0; key_valid=0; key_release=0; key_held=0; all counters, synchronizer and accumulators cleared. Reset applied mid-frame or mid-press aborts everything; no pulse is emitted.
- col passes through a 2-flop synchronizer (2-cycle latency).
- Scan:
  - div_cnt counts 0..SCAN_DIV-1; row = ~(4'b0001 << row_idx).
  - At div_cnt==SCAN_DIV-1, the synchronized col is captured into hit[row_idx][3:0], then row_idx increments (3 wraps to 0) and div_cnt returns to 0.
  - Frame length = 4*SCAN_DIV cycles.
- Frame classification, on the cycle after the row-3 capture:
  - NONE: no low bits captured.
  - SINGLE: exactly one low bit across all 16; code = {row, col}.
  - MULTI: two or more low bits.
  - Accumulators clear after classification.
- Debounce:
  - Registers cand (class + code) and cnt.
  - Frame equals cand: cnt increments, saturating at DEBOUNCE_FRAMES.
  - Frame differs: cand takes the new frame, cnt=1.
  - MULTI frame: cnt=0, cand invalid, stable outputs untouched. Ghosting never generates events.
- Stable FSM, states IDLE and PRESSED, evaluated on the edge where cnt reaches DEBOUNCE_FRAMES:
  - IDLE + SINGLE: key_code=code, key_held=1, key_valid pulse; go to PRESSED.
  - PRESSED + SINGLE with a different code: key_code updates, key_valid pulse, stay PRESSED, key_held stays 1, no release pulse.
  - PRESSED + NONE: key_held=0, key_release pulse, key_code retained; go to IDLE.
  - Same class/code as the current stable state: no event.
- key_valid and key_release are never high in the same cycle; each is exactly 1 cycle wide.
- Latency from a clean press to key_valid: at most (DEBOUNCE_FRAMES+1) frames + 3 cycles.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In PRESSED, a frame counter runs on each SINGLE frame with the same code.
  - key_valid re-pulses after REPEAT_DELAY frames, then every REPEAT_RATE frames.
  - Counter clears on code change, release or reset.
- Undefined: exactly one key_valid per accepted press; the counter logic is absent.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame = 16 cycles):
1. Reset asserted for 2 cycles, then released -> row=1110, all outputs 0; row becomes 1101 four cycles later; sequence 1110, 1101, 1011, 0111, 1110 repeats.
2. Press key 5 (col=1101 while row=1101) for 6 frames -> exactly one key_valid pulse within 4 frames + 3 cycles of press; key_code=5, key_held=1, key_state=5'b10101.
3. Bounce: key 2 toggled down 1 frame / up 1 frame, 4 times -> no key_valid, no key_release, key_held stays 0.
4. Release key 5 after test 2 -> key_release pulse after 3 NONE frames; key_held=0; key_code stays 5; key_state=5'b00101.
5. Keys 0 and 15 both down 5 frames -> no events; then release 15 -> key_valid with key_code=0 after 3 frames. Reset mid-press -> all outputs 0 next cycle, no release pulse.
6. KEY_REPEAT_EN with REPEAT_DELAY=4, REPEAT_RATE=2, key 9 held 12 frames -> initial pulse, repeat 4 frames later, then one every 2 frames. Without the macro -> one pulse only.
